serdes_link_ctrl: RTL and testbench

Bring-up and link-supervision sequencer for the CC_SERDES lane in loopback/link designs. It drives the PLL and TRX reset inputs in order and waits for reset-done. It then qualifies RX alignment against the fixed TX pattern (K28.5 + 16'hCAFE in RX_DATA[23:0]) and supervises the established link, retrying or faulting on loss. It sits between the top-level enable/status logic and the CC_SERDES instance, replacing direct board-pin resets.

---
 rtl/serdes_ctrl_pkg.sv | 24 ++
 rtl/serdes_word_checker.sv | 71 +++++++
 rtl/serdes_link_ctrl.sv | 146 ++++++++++++++
 tb/tb_serdes_link_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_ctrl_pkg.sv
// Shared definitions for the CC_SERDES bring-up sequencer and the TX pattern generators.
// Holds the state encoding, the alignment pattern and the K-character constants.
package serdes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_PLL_WAIT  = 3'd2,
        ST_TRX_RST   = 3'd3,
        ST_DONE_WAIT = 3'd4,
        ST_ALIGN     = 3'd5,
        ST_LINK_UP   = 3'd6,
        ST_FAULT     = 3'd7
    } state_e;

    localparam logic [7:0]  K28_5           = 8'hBC;
    localparam logic [15:0] ALIGN_WORD      = 16'hCAFE;
    localparam logic [23:0] PATTERN_DEFAULT = {ALIGN_WORD, K28_5};

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serdes_word_checker.sv
// Classifies each RX word against the fixed TX pattern and keeps the good/bad run
// counters plus the saturating error count used by the link sequencer.
module serdes_word_checker
    import serdes_ctrl_pkg::*;
#(
    parameter logic [23:0] PATTERN    = PATTERN_DEFAULT,
    parameter int unsigned ALIGN_GOOD = 64,
    parameter int unsigned ERR_LIMIT  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        align_en_i,
    input  logic        link_en_i,
    input  logic        err_clr_i,
    input  logic        tx_buf_err_i,
    input  logic        rx_buf_err_i,
    input  logic [23:0] rx_word_i,
    output logic        aligned_o,
    output logic        drop_o,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned GOOD_W = $clog2(ALIGN_GOOD + 1);
    localparam int unsigned BAD_W  = $clog2(ERR_LIMIT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(ALIGN_GOOD - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(ERR_LIMIT - 1);

    logic              good_w;
    logic [GOOD_W-1:0] good_run_q, good_run_d;
    logic [BAD_W-1:0]  bad_run_q, bad_run_d;
    logic [15:0]       err_cnt_q, err_cnt_d, err_base;

    always_comb begin
        good_w = (rx_word_i == PATTERN) && !tx_buf_err_i && !rx_buf_err_i;

        // Run counters only live inside their own state; leaving it clears them.
        good_run_d = '0;
        if (align_en_i && good_w) begin
            good_run_d = (good_run_q == GOOD_LAST) ? good_run_q : good_run_q + GOOD_W'(1);
        end
        aligned_o = align_en_i && good_w && (good_run_q == GOOD_LAST);

        bad_run_d = '0;
        if (link_en_i && !good_w) begin
            bad_run_d = (bad_run_q == BAD_LAST) ? bad_run_q : bad_run_q + BAD_W'(1);
        end
        drop_o = link_en_i && !good_w && (bad_run_q == BAD_LAST);

        // A clear coinciding with a bad word leaves a count of one.
        err_base  = err_clr_i ? '0 : err_cnt_q;
        err_cnt_d = err_base;
        if (link_en_i && !good_w && (err_base != 16'hFFFF)) begin
            err_cnt_d = err_base + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            good_run_q <= '0;
            bad_run_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/serdes_link_ctrl.sv
// Bring-up and supervision sequencer for one CC_SERDES lane: ordered PLL/TRX resets,
// reset-done wait, pattern alignment, link monitoring with bounded retries.
module serdes_link_ctrl
    import serdes_ctrl_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES  = 16,
    parameter int unsigned PLL_LOCK_CYCLES = 1024,
    parameter int unsigned TRX_RST_CYCLES  = 16,
    parameter int unsigned DONE_TIMEOUT    = 4096,
    parameter int unsigned ALIGN_TIMEOUT   = 8192,
    parameter int unsigned ALIGN_GOOD      = 64,
    parameter int unsigned ERR_LIMIT       = 4,
    parameter int unsigned MAX_RETRIES     = 7,
    parameter logic [23:0] PATTERN         = PATTERN_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        restart_i,
    input  logic        err_clr_i,
    input  logic        tx_reset_done_i,
    input  logic        rx_reset_done_i,
    input  logic        tx_buf_err_i,
    input  logic        rx_buf_err_i,
    input  logic [63:0] rx_data_i,
    output logic        pll_rst_o,
    output logic        trx_rst_o,
    output logic        link_up_o,
    output logic        fault_o,
    output logic [2:0]  state_o,
    output logic [2:0]  retry_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam int unsigned TIMER_MAX = max2(max2(max2(PLL_RST_CYCLES, TRX_RST_CYCLES),
                                                  PLL_LOCK_CYCLES),
                                             max2(DONE_TIMEOUT, ALIGN_TIMEOUT));
    localparam int unsigned TIMER_W = $clog2(TIMER_MAX);
    localparam logic [TIMER_W-1:0] PLL_RST_LAST  = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PLL_LOCK_LAST = TIMER_W'(PLL_LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TRX_RST_LAST  = TIMER_W'(TRX_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DONE_LAST     = TIMER_W'(DONE_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ALIGN_LAST    = TIMER_W'(ALIGN_TIMEOUT - 1);
    localparam logic [2:0]         RETRY_MAX     = 3'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d, trx_rst_q, trx_rst_d;
    logic               link_up_q, link_up_d, fault_q, fault_d;
    logic               fail, aligned, drop, both_done;
    logic               unused_rx_hi;

    assign unused_rx_hi = ^rx_data_i[63:24];
    assign both_done    = tx_reset_done_i && rx_reset_done_i;

    serdes_word_checker #(
        .PATTERN    (PATTERN),
        .ALIGN_GOOD (ALIGN_GOOD),
        .ERR_LIMIT  (ERR_LIMIT)
    ) u_checker (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .align_en_i   (state_q == ST_ALIGN),
        .link_en_i    (state_q == ST_LINK_UP),
        .err_clr_i    (err_clr_i),
        .tx_buf_err_i (tx_buf_err_i),
        .rx_buf_err_i (rx_buf_err_i),
        .rx_word_i    (rx_data_i[23:0]),
        .aligned_o    (aligned),
        .drop_o       (drop),
        .err_cnt_o    (err_cnt_o)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail    = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            // Success is tested before the timeout so a same-cycle done flag wins.
            unique case (state_q)
                ST_IDLE:      begin state_d = ST_PLL_RST; retry_d = '0; end
                ST_PLL_RST:   if (timer_q == PLL_RST_LAST)  state_d = ST_PLL_WAIT;
                ST_PLL_WAIT:  if (timer_q == PLL_LOCK_LAST) state_d = ST_TRX_RST;
                ST_TRX_RST:   if (timer_q == TRX_RST_LAST)  state_d = ST_DONE_WAIT;
                ST_DONE_WAIT: if (both_done) state_d = ST_ALIGN;
                              else if (timer_q == DONE_LAST) fail = 1'b1;
                ST_ALIGN:     if (aligned) state_d = ST_LINK_UP;
                              else if (timer_q == ALIGN_LAST) fail = 1'b1;
                ST_LINK_UP:   if (drop || !both_done) fail = 1'b1;
                ST_FAULT:     if (restart_i) begin state_d = ST_PLL_RST; retry_d = '0; end
                default:      state_d = ST_IDLE;
            endcase
            if (fail) begin
                if (retry_q == RETRY_MAX) begin
                    state_d = ST_FAULT;
                end else begin
                    retry_d = retry_q + 3'd1;
                    state_d = ST_PLL_RST;
                end
            end
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
        end

        pll_rst_d = (state_d == ST_IDLE) || (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        trx_rst_d = !((state_d == ST_DONE_WAIT) || (state_d == ST_ALIGN) ||
                      (state_d == ST_LINK_UP));
        link_up_d = (state_d == ST_LINK_UP);
        fault_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            trx_rst_q <= 1'b1;
            link_up_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            trx_rst_q <= trx_rst_d;
            link_up_q <= link_up_d;
            fault_q   <= fault_d;
        end
    end

    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign pll_rst_o   = pll_rst_q;
    assign trx_rst_o   = trx_rst_q;
    assign link_up_o   = link_up_q;
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Directed bench for serdes_link_ctrl: exact phase lengths, alignment, link drop,
// timeouts, retry exhaustion, enable drop, error counter saturation and async reset.
module tb_serdes_link_ctrl;

    localparam logic [63:0] GOOD_WORD = 64'hDEAD_BEEF_55CA_FEBC;
    localparam logic [63:0] BAD_WORD  = 64'hDEAD_BEEF_55CA_FEBD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, restart = 1'b0, err_clr = 1'b0;
    logic        tx_done = 1'b0, rx_done = 1'b0, tx_buf_err = 1'b0, rx_buf_err = 1'b0;
    logic [63:0] rx_data = 64'd0;
    logic        pll_rst, trx_rst, link_up, fault;
    logic [2:0]  state, retry_cnt;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serdes_link_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .restart_i       (restart),
        .err_clr_i       (err_clr),
        .tx_reset_done_i (tx_done),
        .rx_reset_done_i (rx_done),
        .tx_buf_err_i    (tx_buf_err),
        .rx_buf_err_i    (rx_buf_err),
        .rx_data_i       (rx_data),
        .pll_rst_o       (pll_rst),
        .trx_rst_o       (trx_rst),
        .link_up_o       (link_up),
        .fault_o         (fault),
        .state_o         (state),
        .retry_cnt_o     (retry_cnt),
        .err_cnt_o       (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int bound);
        int n;
        n = 0;
        while (state !== st && n < bound) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(state), 32'(st));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pll"},   32'(pll_rst),   1);
        check_eq({tag, "_trx"},   32'(trx_rst),   1);
        check_eq({tag, "_link"},  32'(link_up),   0);
        check_eq({tag, "_fault"}, 32'(fault),     0);
        check_eq({tag, "_state"}, 32'(state),     0);
        check_eq({tag, "_retry"}, 32'(retry_cnt), 0);
        check_eq({tag, "_err"},   32'(err_cnt),   0);
    endtask

    initial begin
        // Reset and idle
        ticks(3);
        check_reset_vals("rst");
        rst = 1'b0;
        tick();
        check_eq("idle_state", 32'(state), 0);

        // Nominal bring-up with exact phase lengths
        enable = 1'b1;
        tick();
        check_eq("pllrst_enter", 32'(state), 1);
        ticks(15);
        check_eq("pllrst_last", 32'(pll_rst), 1);
        tick();
        check_eq("pllwait_state", 32'(state), 2);
        check_eq("pllwait_pll", 32'(pll_rst), 0);
        check_eq("pllwait_trx", 32'(trx_rst), 1);
        ticks(1023);
        check_eq("pllwait_last", 32'(state), 2);
        tick();
        check_eq("trxrst_state", 32'(state), 3);
        ticks(15);
        check_eq("trxrst_last", 32'(trx_rst), 1);
        tick();
        check_eq("donewait_state", 32'(state), 4);
        check_eq("donewait_trx", 32'(trx_rst), 0);
        ticks(10);
        check_eq("donewait_hold", 32'(state), 4);
        tx_done = 1'b1;
        rx_done = 1'b1;
        tick();
        check_eq("align_enter", 32'(state), 5);
        rx_data = GOOD_WORD;
        ticks(10);
        rx_buf_err = 1'b1;
        tick();
        rx_buf_err = 1'b0;
        ticks(63);
        check_eq("align_63_state", 32'(state), 5);
        check_eq("align_63_link", 32'(link_up), 0);
        tick();
        check_eq("linkup_link", 32'(link_up), 1);
        check_eq("linkup_state", 32'(state), 6);
        check_eq("linkup_retry", 32'(retry_cnt), 0);
        check_eq("linkup_err", 32'(err_cnt), 0);

        // Link drop: 3 bad + 1 good holds, then 4 bad drops
        rx_data = BAD_WORD;
        ticks(3);
        check_eq("bad3_link", 32'(link_up), 1);
        check_eq("bad3_err", 32'(err_cnt), 3);
        rx_data = GOOD_WORD;
        tick();
        check_eq("good_link", 32'(link_up), 1);
        rx_data = BAD_WORD;
        ticks(3);
        check_eq("bad3b_link", 32'(link_up), 1);
        check_eq("bad3b_err", 32'(err_cnt), 6);
        tick();
        check_eq("drop_link", 32'(link_up), 0);
        check_eq("drop_pll", 32'(pll_rst), 1);
        check_eq("drop_state", 32'(state), 1);
        check_eq("drop_retry", 32'(retry_cnt), 1);
        check_eq("drop_err", 32'(err_cnt), 7);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("errclr", 32'(err_cnt), 0);

        // Enable dropped mid-ALIGN
        rx_data = GOOD_WORD;
        wait_state("reach_align", 3'd5, 1100);
        ticks(5);
        enable = 1'b0;
        tick();
        check_eq("dis_state", 32'(state), 0);
        check_eq("dis_pll", 32'(pll_rst), 1);
        check_eq("dis_trx", 32'(trx_rst), 1);
        check_eq("dis_retry", 32'(retry_cnt), 1);

        // Done timeout: exactly DONE_TIMEOUT cycles in DONE_WAIT
        rx_done = 1'b0;
        enable = 1'b1;
        tick();
        check_eq("reen_state", 32'(state), 1);
        check_eq("reen_retry", 32'(retry_cnt), 0);
        wait_state("reach_done1", 3'd4, 1100);
        ticks(4095);
        check_eq("tmo_last", 32'(state), 4);
        tick();
        check_eq("tmo_state", 32'(state), 1);
        check_eq("tmo_retry", 32'(retry_cnt), 1);

        // Done flags on the timeout cycle count as success
        wait_state("reach_done2", 3'd4, 1100);
        ticks(4095);
        rx_done = 1'b1;
        tick();
        check_eq("tie_state", 32'(state), 5);
        check_eq("tie_retry", 32'(retry_cnt), 1);
        wait_state("reach_link2", 3'd6, 100);
        rx_done = 1'b0;
        tick();
        check_eq("doneloss_state", 32'(state), 1);
        check_eq("doneloss_retry", 32'(retry_cnt), 2);

        // Exhaustion through repeated done timeouts
        for (int r = 3; r <= 7; r++) begin
            wait_state("ex_done", 3'd4, 1100);
            wait_state("ex_retry_st", 3'd1, 4200);
            check_eq("ex_retry", 32'(retry_cnt), 32'(r));
        end
        wait_state("ex_done_last", 3'd4, 1100);
        wait_state("fault_state", 3'd7, 4200);
        check_eq("fault_o", 32'(fault), 1);
        check_eq("fault_pll", 32'(pll_rst), 1);
        check_eq("fault_trx", 32'(trx_rst), 1);
        check_eq("fault_retry", 32'(retry_cnt), 7);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("restart_state", 32'(state), 1);
        check_eq("restart_retry", 32'(retry_cnt), 0);
        check_eq("restart_fault", 32'(fault), 0);

        // Error counter saturation and clear-with-bad-word
        rx_done = 1'b1;
        wait_state("reach_link3", 3'd6, 1200);
        force dut.u_checker.err_cnt_q = 16'hFFFE;
        #1;
        release dut.u_checker.err_cnt_q;
        rx_data = BAD_WORD;
        tick();
        check_eq("sat_1", 32'(err_cnt), 32'h0000_FFFF);
        tick();
        check_eq("sat_2", 32'(err_cnt), 32'h0000_FFFF);
        rx_data = GOOD_WORD;
        tick();
        rx_data = BAD_WORD;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        rx_data = GOOD_WORD;
        check_eq("clr_bad", 32'(err_cnt), 1);
        tick();
        check_eq("sat_link", 32'(link_up), 1);

        // Asynchronous reset mid-LINK_UP
        rst = 1'b1;
        #2;
        check_reset_vals("arst");
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
